// File: rtl/mul_issue.sv
// Request/response front end for the iterative add-shift multiplier: accepts one op, drives en/done, returns a product half.
// Optional one-entry result cache enabled by defining MUL_ISSUE_CACHE_EN.
module mul_issue #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic [TAG_W-1:0]    resp_tag,
  output logic                resp_err,
  output logic                busy,
  output logic                mul_en,
  output logic                mul_sign,
  output logic [DATA_W-1:0]   mul_op_a,
  output logic [DATA_W-1:0]   mul_op_b,
  input  logic                mul_done,
  input  logic [2*DATA_W-1:0] mul_product
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t              state, state_nxt;
  logic [1:0]          op_q, op_nxt;
  logic                accept, legal, hit;
  logic [2*DATA_W-1:0] hit_prod;

  logic                req_ready_nxt, resp_valid_nxt, resp_err_nxt, busy_nxt;
  logic                mul_en_nxt, mul_sign_nxt;
  logic [DATA_W-1:0]   resp_data_nxt, mul_op_a_nxt, mul_op_b_nxt;
  logic [TAG_W-1:0]    resp_tag_nxt;

  function automatic logic [DATA_W-1:0] pick_half(input logic [1:0] op,
                                                  input logic [2*DATA_W-1:0] prod);
    return (op == 2'd0) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
  endfunction

  // flush in IDLE blocks acceptance for that cycle
  assign accept = (state == IDLE) && req_valid && !flush;
  assign legal  = (req_op != 2'd3);

`ifdef MUL_ISSUE_CACHE_EN
  logic                cache_valid;
  logic [DATA_W-1:0]   cache_a, cache_b;
  logic                cache_sign;
  logic [2*DATA_W-1:0] cache_prod;

  assign hit      = cache_valid && (cache_a == req_a) && (cache_b == req_b)
                    && (cache_sign == (req_op == 2'd1));
  assign hit_prod = cache_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      cache_a     <= '0;
      cache_b     <= '0;
      cache_sign  <= 1'b0;
      cache_prod  <= '0;
    end else if (flush) begin
      cache_valid <= 1'b0;
    end else if (state == RUN && mul_done) begin
      cache_valid <= 1'b1;
      cache_a     <= mul_op_a;
      cache_b     <= mul_op_b;
      cache_sign  <= mul_sign;
      cache_prod  <= mul_product;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_prod = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (!legal || hit) ? RESP : RUN;
      RUN:     if (flush) state_nxt = IDLE;
               else if (mul_done) state_nxt = RESP;
      RESP:    if (flush || resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_nxt         = op_q;
    resp_valid_nxt = resp_valid;
    resp_err_nxt   = resp_err;
    resp_data_nxt  = resp_data;
    resp_tag_nxt   = resp_tag;
    mul_en_nxt     = mul_en;
    mul_sign_nxt   = mul_sign;
    mul_op_a_nxt   = mul_op_a;
    mul_op_b_nxt   = mul_op_b;
    case (state)
      IDLE: begin
        if (accept) begin
          op_nxt       = req_op;
          resp_tag_nxt = req_tag;
          mul_op_a_nxt = req_a;
          mul_op_b_nxt = req_b;
          mul_sign_nxt = (req_op == 2'd1);
          if (!legal) begin
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
            resp_data_nxt  = '0;
          end else if (hit) begin
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b0;
            resp_data_nxt  = pick_half(req_op, hit_prod);
          end else begin
            mul_en_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (flush) begin
          mul_en_nxt = 1'b0;
        end else if (mul_done) begin
          mul_en_nxt     = 1'b0;
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b0;
          resp_data_nxt  = pick_half(op_q, mul_product);
        end
      end
      RESP: begin
        if (flush || resp_ready) resp_valid_nxt = 1'b0;
      end
      default: begin
        mul_en_nxt     = 1'b0;
        resp_valid_nxt = 1'b0;
      end
    endcase
    req_ready_nxt = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 2'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
      busy       <= 1'b0;
      mul_en     <= 1'b0;
      mul_sign   <= 1'b0;
      mul_op_a   <= '0;
      mul_op_b   <= '0;
    end else begin
      op_q       <= op_nxt;
      req_ready  <= req_ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_err   <= resp_err_nxt;
      resp_data  <= resp_data_nxt;
      resp_tag   <= resp_tag_nxt;
      busy       <= busy_nxt;
      mul_en     <= mul_en_nxt;
      mul_sign   <= mul_sign_nxt;
      mul_op_a   <= mul_op_a_nxt;
      mul_op_b   <= mul_op_b_nxt;
    end
  end

endmodule

// File: tb/tb_mul_issue.sv
// Bench for mul_issue: behavioural sibling multiplier plus arithmetic reference model, randomized ops.
module tb_mul_issue;
  localparam int DW = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic [TW-1:0] req_tag = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic [TW-1:0] resp_tag;
  logic          resp_err;
  logic          busy;
  logic          mul_en;
  logic          mul_sign;
  logic [DW-1:0] mul_op_a;
  logic [DW-1:0] mul_op_b;
  logic          mul_done;
  logic [2*DW-1:0] mul_product;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // cache model state
  logic          cache_v = 1'b0;
  logic [DW-1:0] ca, cb;
  logic          cs;

  always #5 clk = ~clk;

  mul_issue #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err), .busy(busy),
    .mul_en(mul_en), .mul_sign(mul_sign), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  // Sibling multiplier: DW enabled cycles, then a one-cycle done pulse with the product.
  int unsigned pc;
  logic [2*DW-1:0] prod_s, prod_u;
  assign prod_s = $signed({{DW{mul_op_a[DW-1]}}, mul_op_a}) * $signed({{DW{mul_op_b[DW-1]}}, mul_op_b});
  assign prod_u = {{DW{1'b0}}, mul_op_a} * {{DW{1'b0}}, mul_op_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= 0; mul_done <= 1'b0; mul_product <= '0;
    end else if (!mul_en) begin
      pc <= 0; mul_done <= 1'b0;
    end else begin
      pc <= pc + 1;
      mul_done <= (pc == DW - 1);
      if (pc == DW - 1) mul_product <= mul_sign ? prod_s : prod_u;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_result(input logic [1:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    longint          s;
    longint unsigned u;
    logic [63:0]     p;
    s = int'(a);
    s = s * int'(b);
    u = a;
    u = u * b;
    p = s;
    case (op)
      2'd0:    return u[31:0];
      2'd1:    return p[63:32];
      2'd2:    return u[63:32];
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] tag, input int unsigned hold);
    logic [DW-1:0] exp_data;
    logic          exp_err, hit, en_seen;
    int unsigned   exp_lat, lat;
    exp_err  = (op == 2'd3);
    exp_data = ref_result(op, a, b);
    hit      = 1'b0;
`ifdef MUL_ISSUE_CACHE_EN
    hit = !exp_err && cache_v && ca == a && cb == b && cs == (op == 2'd1);
`endif
    exp_lat = (exp_err || hit) ? 1 : DW + 2;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    lat = 0;
    while (!req_ready && lat < 200) begin @(negedge clk); lat++; end
    check("req_ready_before_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    en_seen = mul_en;
    if (!exp_err && !hit) begin
      check("mul_sign", mul_sign, op == 2'd1);
      check("mul_op_a", mul_op_a, a);
      check("mul_op_b", mul_op_b, b);
    end
    while (!resp_valid && lat < 200) begin
      @(negedge clk); lat++; en_seen |= mul_en;
    end
    check("latency", lat, exp_lat);
    check("mul_en_seen", en_seen, !(exp_err || hit));
    check("resp_valid", resp_valid, 1);
    check("resp_data", resp_data, exp_data);
    check("resp_tag", resp_tag, tag);
    check("resp_err", resp_err, exp_err);
    check("req_ready_in_resp", req_ready, 0);
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_data", resp_data, exp_data);
      check("hold_tag", resp_tag, tag);
      check("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_after_hs", resp_valid, 0);
    check("req_ready_after_hs", req_ready, 1);
    check("busy_after_hs", busy, 0);
    if (!exp_err && !hit) begin
      cache_v = 1'b1; ca = a; cb = b; cs = (op == 2'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] a, b;
    int unsigned   seen;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_en", mul_en, 0);
    check("rst_mul_sign", mul_sign, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_tag", resp_tag, 0);
    check("rst_mul_op_a", mul_op_a, 0);
    check("rst_mul_op_b", mul_op_b, 0);
    rst_n = 1'b1;

    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 0);
    issue(2'd0, 32'h0001_0003, 32'h0002_0005, 4'd1, 1);
    issue(2'd1, 32'hFFFF_FFFD, 32'd7, 4'd3, 0);
    issue(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 4'd2, 0);
    issue(2'd0, 32'd100, 32'd200, 4'd9, 10);

    // flush during cycle 10 of RUN
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_a = 32'd123; req_b = 32'd456; req_tag = 4'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mul_en_before_flush", mul_en, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cache_v = 1'b0;
    check("flush_mul_en", mul_en, 0);
    check("flush_resp_valid", resp_valid, 0);
    check("flush_req_ready", req_ready, 1);
    seen = 0;
    repeat (40) begin @(negedge clk); seen += resp_valid; end
    check("flush_no_resp", seen, 0);
    issue(2'd0, 32'd6, 32'd7, 4'd4, 0);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = 2'd0; req_a = 32'd5; req_b = 32'd5;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    cache_v = 1'b0;
    check("idle_flush_busy", busy, 0);
    check("idle_flush_req_ready", req_ready, 1);
    check("idle_flush_mul_en", mul_en, 0);

    // cached MULHU after MUL on the same operands
    issue(2'd0, 32'd9, 32'd11, 4'd6, 0);
    issue(2'd2, 32'd9, 32'd11, 4'd8, 0);

    for (int unsigned k = 0; k < 24; k++) begin
      if (cache_v && $urandom_range(0, 3) == 0) begin a = ca; b = cb; end
      else begin a = rnd_operand(); b = rnd_operand(); end
      issue(2'($urandom_range(0, 3)), a, b, 4'($urandom), $urandom_range(0, 3));
    end

    // asynchronous reset mid-operation
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd77; req_b = 32'd88; req_tag = 4'd1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    cache_v = 1'b0;
    check("arst_mul_en", mul_en, 0);
    check("arst_req_ready", req_ready, 1);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'd1, 32'h8000_0000, 32'h8000_0000, 4'd15, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
